alu_multiword_seq: RTL and testbench
====================================

Name: alu_multiword_seq

Overview:
- Multi-cycle sequencer that drives the bus-wide ALU adder one word per clock, performing WORDS×BUS-bit add/subtract with ripple carry held in a register.
- Sits between the execute stage and the shared ALU instance.
- Owns the ALU's a/b/cin/c2 inputs while busy, collects sout/cout into a wide result, and reports flags for the whole operand.

Parameters:
- BUS, 8, width of one ALU word (must match the ALU's bus parameter).
- WORDS, 4, number of words per operand; must be ≥2; total width W = BUS*WORDS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = add, 1 = subtract (opa − opb); sampled with start.
- opa  in  W  operand A; captured on accept.
- opb  in  W  operand B; captured on accept.
- alu_a  out  BUS  word of A presented to the ALU.
- alu_b  out  BUS  word of B presented to the ALU (already inverted for subtract).
- alu_cin  out  1  ALU carry-in.
- alu_c2  out  1  ALU c2 control; always driven 0.
- alu_sout  in  BUS  ALU sum word.
- alu_cout  in  1  ALU carry-out.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- result  out  W  full result; valid from done onward until the next accept.
- carry  out  1  final carry-out; for subtract, 1 = no borrow.
- zero  out  1  result == 0 over all W bits.
- overflow  out  1  signed overflow of the W-bit operation.
- negative  out  1  result[W-1].

Behaviour:
- States: IDLE, RUN, DONE. Word index idx counts 0..WORDS-1. Carry register cr.
- Reset: state = IDLE; idx = 0; cr = 0. All of busy, done, result, carry, zero, overflow and negative = 0. Operand registers = 0. Reset asserted in any state aborts the operation on that edge with no done pulse.
- IDLE, start=1 at edge k:
  - Capture opa, opb and op.
  - Set cr = op (cin = 1 on word 0 for subtract). Set idx = 0.
  - Go to RUN. result is not cleared.
- RUN, combinational drive:
  - alu_a = A word idx.
  - alu_b = B word idx, XOR-ed with all op bits.
  - alu_cin = cr. alu_c2 = 0.
- RUN, each edge:
  - result word idx <= alu_sout; cr <= alu_cout; idx++.
  - On the edge where idx = WORDS-1, also:
    - carry <= alu_cout.
    - overflow <= (a_msb == b_eff_msb) && (sout_msb != a_msb), computed on the top word, where b_eff is the possibly inverted B.
    - Go to DONE.
- Latency: done is high in the cycle after edge k+WORDS, i.e. WORDS edges after the accepting edge. busy is high between edge k and edge k+WORDS.
- DONE:
  - done = 1 for exactly one cycle; next edge goes to IDLE.
  - start is ignored in RUN and DONE and is not queued. Next accept is possible no earlier than the first IDLE cycle.
- zero and negative are derived combinationally from the registered result, gated to 0 unless the state is DONE or IDLE after a completed operation. They hold until the next accept.
- Outside RUN, alu_a, alu_b and alu_cin are 0.
- Width: idx is clog2(WORDS) bits. Carry chaining is purely through cr, and no wrap of idx beyond WORDS-1 occurs.

Optional Feature:
- Macro: ALU_MULTIWORD_SEQ_SAT_EN.
- Defined: when overflow is 1 on completion, result is replaced with the signed limit, 0x7F..F if the A sign is 0, else 0x80..0. overflow stays 1; zero and negative follow the saturated value.
- Undefined: result is the wrapped W-bit sum; no saturation logic is present.

Test Plan (BUS=8, WORDS=4):
- Add 0x000000FF + 0x00000001, start at edge k -> done at cycle k+4:
  - result 0x00000100, carry 0, zero 0, overflow 0, negative 0.
  - alu_cin seen 0,1,0,0.
- Subtract 0x00000000 − 0x00000001 -> result 0xFFFFFFFF, carry 0, negative 1, overflow 0; alu_b word 0 = 0xFE, alu_cin word 0 = 1.
- Add 0x7FFFFFFF + 0x00000001:
  - Macro off -> result 0x80000000, overflow 1.
  - Macro on -> result 0x7FFFFFFF, overflow 1, negative 0.
- Subtract 0x12345678 − 0x12345678 -> result 0, zero 1, carry 1.
- Assert start again at k+2 during RUN -> ignored: single done at k+4, no second operation, busy low after k+4.
- Assert rst at k+2 -> IDLE at k+3 with all outputs 0 and no done pulse; a new start at k+4 completes correctly at k+8.

Source files
------------

// File: rtl/alu_multiword_seq.sv
// Multi-word add/subtract sequencer: feeds an external BUS-bit ALU one word per clock
// and chains the carry through a register. Saturation is enabled by ALU_MULTIWORD_SEQ_SAT_EN.
module alu_multiword_seq #(
   parameter int unsigned BUS   = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 op,
   input  logic [BUS*WORDS-1:0] opa,
   input  logic [BUS*WORDS-1:0] opb,
   output logic [BUS-1:0]       alu_a,
   output logic [BUS-1:0]       alu_b,
   output logic                 alu_cin,
   output logic                 alu_c2,
   input  logic [BUS-1:0]       alu_sout,
   input  logic                 alu_cout,
   output logic                 busy,
   output logic                 done,
   output logic [BUS*WORDS-1:0] result,
   output logic                 carry,
   output logic                 zero,
   output logic                 overflow,
   output logic                 negative
);

   localparam int unsigned W     = BUS * WORDS;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cr_q, cr_d;
   logic             op_q, op_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     result_q, result_d;
   logic             carry_q, carry_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic             ovf_w;

   // Next-state, ALU drive and result collection
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cr_d       = cr_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      valid_d    = valid_q;
      alu_a      = '0;
      alu_b      = '0;
      alu_cin    = 1'b0;
      ovf_w      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = opa;
               b_d     = opb;
               op_d    = op;
               cr_d    = op;
               idx_d   = '0;
               busy_d  = 1'b1;
               valid_d = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            alu_a   = a_q[idx_q*BUS +: BUS];
            alu_b   = b_q[idx_q*BUS +: BUS] ^ {BUS{op_q}};
            alu_cin = cr_q;
            ovf_w   = (alu_a[BUS-1] == alu_b[BUS-1]) && (alu_sout[BUS-1] != alu_a[BUS-1]);
            result_d[idx_q*BUS +: BUS] = alu_sout;
            cr_d    = alu_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(WORDS - 1)) begin
               carry_d    = alu_cout;
               overflow_d = ovf_w;
               idx_d      = '0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               valid_d    = 1'b1;
               state_d    = S_DONE;
`ifdef ALU_MULTIWORD_SEQ_SAT_EN
               // Clamp to the signed limit on the side of operand A's sign
               if (ovf_w) begin
                  result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
               end
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cr_q       <= 1'b0;
         op_q       <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cr_q       <= cr_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
      end
   end

   assign alu_c2   = 1'b0;
   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign carry    = carry_q;
   assign overflow = overflow_q;
   // Flags only reflect a completed operation
   assign zero     = valid_q & (result_q == '0);
   assign negative = valid_q & result_q[W-1];

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed bench for alu_multiword_seq with a behavioural BUS-bit adder as the ALU.
module tb_alu_multiword_seq;

   localparam int unsigned BUS   = 8;
   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = BUS * WORDS;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           op;
   logic [W-1:0]   opa, opb;
   logic [BUS-1:0] alu_a, alu_b, alu_sout;
   logic           alu_cin, alu_c2, alu_cout;
   logic           busy, done, carry, zero, overflow, negative;
   logic [W-1:0]   result;
   logic [BUS:0]   alu_sum;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{BUS{1'b0}}, alu_cin};
   assign alu_sout = alu_sum[BUS-1:0];
   assign alu_cout = alu_sum[BUS];

   alu_multiword_seq #(.BUS(BUS), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_c2(alu_c2),
      .alu_sout(alu_sout), .alu_cout(alu_cout),
      .busy(busy), .done(done), .result(result), .carry(carry),
      .zero(zero), .overflow(overflow), .negative(negative)
   );

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         v;
      logic         n;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Accept at the next edge, then step through WORDS edges checking drive and final flags
   task automatic run_vec(input vec_t v, input int id);
      logic         c;
      logic [BUS:0] s;
      logic [BUS-1:0] beff;
      @(negedge clk);
      start = 1'b1; op = v.op; opa = v.a; opb = v.b;
      @(posedge clk);
      #1 start = 1'b0;
      c = v.op;
      for (int w = 0; w < int'(WORDS); w++) begin
         @(negedge clk);
         beff = v.b[w*BUS +: BUS] ^ {BUS{v.op}};
         check($sformatf("v%0d busy w%0d", id, w), 64'(busy), 64'(1'b1));
         check($sformatf("v%0d done w%0d", id, w), 64'(done), 64'(1'b0));
         check($sformatf("v%0d alu_cin w%0d", id, w), 64'(alu_cin), 64'(c));
         check($sformatf("v%0d alu_b w%0d", id, w), 64'(alu_b), 64'(beff));
         check($sformatf("v%0d alu_a w%0d", id, w), 64'(alu_a), 64'(v.a[w*BUS +: BUS]));
         s = {1'b0, v.a[w*BUS +: BUS]} + {1'b0, beff} + {{BUS{1'b0}}, c};
         c = s[BUS];
      end
      @(negedge clk);
      check($sformatf("v%0d done", id), 64'(done), 64'(1'b1));
      check($sformatf("v%0d busy end", id), 64'(busy), 64'(1'b0));
      check($sformatf("v%0d result", id), 64'(result), 64'(v.res));
      check($sformatf("v%0d carry", id), 64'(carry), 64'(v.c));
      check($sformatf("v%0d zero", id), 64'(zero), 64'(v.z));
      check($sformatf("v%0d overflow", id), 64'(overflow), 64'(v.v));
      check($sformatf("v%0d negative", id), 64'(negative), 64'(v.n));
      @(negedge clk);
      check($sformatf("v%0d done pulse", id), 64'(done), 64'(1'b0));
      check($sformatf("v%0d zero hold", id), 64'(zero), 64'(v.z));
      check($sformatf("v%0d alu_a idle", id), 64'(alu_a), 64'(0));
   endtask

   initial begin
      //             op    a             b             result        c     z     v     n
      vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ALU_MULTIWORD_SEQ_SAT_EN
      vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1};
`else
      vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
      vecs[3] = '{1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 32'h12345678, 32'h87654321, 32'h99999999, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst result", 64'(result), 64'(0));
      check("rst flags", 64'({carry, zero, overflow, negative}), 64'(0));
      check("rst alu drive", 64'({alu_a, alu_b, alu_cin, alu_c2}), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // start re-asserted mid-operation must be ignored
      @(negedge clk);
      start = 1'b1; op = 1'b0; opa = 32'h00000010; opb = 32'h00000020;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 start = 1'b1; opa = 32'h11111111; opb = 32'h22222222;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ign done", 64'(done), 64'(1));
      check("ign result", 64'(result), 64'(32'h00000030));
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check($sformatf("ign quiet %0d", j), 64'({busy, done}), 64'(0));
      end

      // reset mid-operation aborts without a done pulse
      @(negedge clk);
      start = 1'b1; op = 1'b1; opa = 32'h00000005; opb = 32'h00000003;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      check("abort result", 64'(result), 64'(0));
      check("abort flags", 64'({carry, zero, overflow, negative}), 64'(0));
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check($sformatf("abort quiet %0d", j), 64'(done), 64'(0));
      end
      run_vec('{1'b1, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0}, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
